// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around a single-port 16x16 RAM with a registered output stage.
// Optional synchronous flush port enabled by defining RAM_FIFO_FLUSH_EN.
module ram_fifo_ctrl #(
   parameter int ADSize  = 4,
   parameter int DASize  = 16,
   parameter int RAMSize = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef RAM_FIFO_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DASize-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DASize-1:0] out_data,
   output logic [ADSize:0]   count,
   output logic              en_read,
   output logic              en_write,
   output logic [ADSize-1:0] addr,
   output logic [DASize-1:0] DMin,
   input  logic [DASize-1:0] DMout
);

   localparam logic [ADSize:0]   FULL_COUNT = (ADSize+1)'(RAMSize);
   localparam logic [ADSize-1:0] PTR_ONE    = ADSize'(1);
   localparam logic [ADSize:0]   CNT_ONE    = (ADSize+1)'(1);

   logic [ADSize-1:0] wr_ptr_reg;
   logic [ADSize-1:0] rd_ptr_reg;
   logic [ADSize:0]   count_reg;
   logic              rd_pend_reg;
   logic              out_valid_reg;
   logic [DASize-1:0] out_data_reg;

   logic flush_w;
   logic want_rd;
   logic wr_fire;

`ifdef RAM_FIFO_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // A read is only started when the output stage and the return slot are both free.
   assign want_rd  = (count_reg != '0) && !rd_pend_reg && !out_valid_reg;
   assign in_ready = !rst && !flush_w && (count_reg != FULL_COUNT) && !want_rd;
   assign wr_fire  = in_valid && in_ready;

   assign en_read  = want_rd;
   assign en_write = wr_fire;
   assign addr     = want_rd ? rd_ptr_reg : wr_ptr_reg;
   assign DMin     = rst ? '0 : in_data;

   assign count     = count_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         rd_pend_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (flush_w) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         rd_pend_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         // Port is exclusive, so count moves by at most one per cycle.
         if (want_rd) begin
            rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
            count_reg   <= count_reg - CNT_ONE;
            rd_pend_reg <= 1'b1;
         end else if (wr_fire) begin
            wr_ptr_reg  <= wr_ptr_reg + PTR_ONE;
            count_reg   <= count_reg + CNT_ONE;
         end

         if (rd_pend_reg) begin
            out_data_reg  <= DMout;
            out_valid_reg <= 1'b1;
            rd_pend_reg   <= 1'b0;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read RAM attached.
// Define RAM_FIFO_FLUSH_EN to also exercise the flush port.
module tb_ram_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [4:0]  count;
   logic        en_read;
   logic        en_write;
   logic [3:0]  addr;
   logic [15:0] DMin;
   logic [15:0] DMout;

   logic [15:0] mem [16];
   logic [3:0]  wptr;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (en_write) mem[addr] <= DMin;
      if (en_read) DMout <= mem[addr];
   end

   ram_fifo_ctrl #(.ADSize(4), .DASize(16), .RAMSize(16)) dut (
      .clk(clk),
      .rst(rst),
`ifdef RAM_FIFO_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count),
      .en_read(en_read),
      .en_write(en_write),
      .addr(addr),
      .DMin(DMin),
      .DMout(DMout)
   );

   // Push one word, waiting (bounded) for in_ready; returns just after the accepting edge.
   task automatic push_word(input logic [15:0] d);
      bit ok;
      ok = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL push_timeout data=%h in_ready=%b required=1", d, in_ready);
         in_valid = 1'b0;
         return;
      end
      if (en_write !== 1'b1 || addr !== wptr) begin
         errors++;
         $display("FAIL push_write data=%h en_write=%b addr=%0d required en_write=1 addr=%0d",
                  d, en_write, addr, wptr);
      end
      $display("push data=%h addr=%0d", d, addr);
      wptr = wptr + 4'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Pop n words expected as first, first+1, ...; checks order and 3-cycle spacing.
   task automatic drain(input int n, input logic [15:0] first, input bit expect_empty);
      int cyc;
      int last;
      int got;
      logic [15:0] exp_d;
      cyc = 0; last = -1; got = 0;
      @(negedge clk);
      out_ready = 1'b1;
      while (got < n && cyc < n * 3 + 12) begin
         #1;
         if (count === 5'd0) begin
            checks++;
            if (en_read !== 1'b0) begin
               errors++;
               $display("FAIL read_while_empty en_read=%b required=0", en_read);
            end
         end
         if (out_valid === 1'b1) begin
            exp_d = first + 16'(got);
            checks++;
            if (out_data !== exp_d) begin
               errors++;
               $display("FAIL pop_data out_data=%h required=%h", out_data, exp_d);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 3) begin
                  errors++;
                  $display("FAIL pop_spacing gap=%0d required=3", cyc - last);
               end
            end
            $display("pop data=%h cycle=%0d", out_data, cyc);
            last = cyc;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL drain_timeout got=%0d required=%0d", got, n);
      end
      if (expect_empty) begin
         #1;
         checks++;
         if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty count=%0d out_valid=%b required count=0 out_valid=0",
                     count, out_valid);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wptr = 4'd0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || count !== 5'd0) begin
         errors++;
         $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%h count=%0d required 0,0,0000,0",
                  in_ready, out_valid, out_data, count);
      end
      checks++;
      if (en_read !== 1'b0 || en_write !== 1'b0 || addr !== 4'd0 || DMin !== 16'h0) begin
         errors++;
         $display("FAIL reset_ram_pins en_read=%b en_write=%b addr=%0d DMin=%h required 0,0,0,0000",
                  en_read, en_write, addr, DMin);
      end
      @(negedge clk);
      rst = 1'b0;
      wptr = 4'd0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset in_ready=%b required=1", in_ready);
      end
      $display("reset checked");
   endtask

   task automatic test_push7();
      push_word(16'd1);
      checks++;
      if (en_read !== 1'b1 || addr !== 4'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL first_read en_read=%b addr=%0d in_ready=%b required 1,0,0",
                  en_read, addr, in_ready);
      end
      push_word(16'd2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd1) begin
         errors++;
         $display("FAIL read_latency out_valid=%b out_data=%h required 1,0001", out_valid, out_data);
      end
      for (int i = 3; i <= 7; i++) push_word(16'(i));
      checks++;
      if (count !== 5'd6 || out_valid !== 1'b1 || out_data !== 16'd1) begin
         errors++;
         $display("FAIL push7_end count=%0d out_valid=%b out_data=%h required 6,1,0001",
                  count, out_valid, out_data);
      end
   endtask

   task automatic test_drain7();
      drain(7, 16'd1, 1'b1);
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if (en_read !== 1'b0) begin
            errors++;
            $display("FAIL idle_read en_read=%b required=0", en_read);
         end
      end
   endtask

   task automatic test_full();
      // A primer word parks in the output stage so no further reads are issued while filling.
      push_word(16'h9999);
      for (int i = 0; i < 16; i++) push_word(16'hA000 + 16'(i));
      checks++;
      if (count !== 5'd16 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_state count=%0d in_ready=%b required 16,0", count, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      repeat (3) begin
         #1;
         checks++;
         if (en_write !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_reject en_write=%b in_ready=%b required 0,0", en_write, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (count !== 5'd16) begin
         errors++;
         $display("FAIL full_hold count=%0d required=16", count);
      end
      drain(1, 16'h9999, 1'b0);
      drain(16, 16'hA000, 1'b1);
   endtask

   task automatic test_rst_midread();
      do_reset();
      push_word(16'hD001);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midread_reset count=%0d out_valid=%b in_ready=%b required 0,0,0",
                  count, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wptr = 4'd0;
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL abandoned_read out_valid=%b count=%0d required 0,0", out_valid, count);
         end
      end
      push_word(16'hD002);
      drain(1, 16'hD002, 1'b1);
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 10; i++) push_word(16'hC000 + 16'(i));
      checks++;
      if (count !== 5'd9) begin
         errors++;
         $display("FAIL wrap_fill count=%0d required=9", count);
      end
      drain(10, 16'hC000, 1'b1);
      for (int i = 0; i < 10; i++) push_word(16'hB000 + 16'(i));
      drain(10, 16'hB000, 1'b1);
   endtask

`ifdef RAM_FIFO_FLUSH_EN
   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) push_word(16'hF000 + 16'(i));
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hBAD0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || en_write !== 1'b0) begin
         errors++;
         $display("FAIL flush_block in_ready=%b en_write=%b required 0,0", in_ready, en_write);
      end
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      wptr     = 4'd0;
      checks++;
      if (count !== 5'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_state count=%0d out_valid=%b required 0,0", count, out_valid);
      end
      push_word(16'hE0E0);
      drain(1, 16'hE0E0, 1'b1);
   endtask
`endif

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h1234;
      out_ready = 1'b0;
      wptr      = 4'd0;
      test_reset();
      test_push7();
      test_drain7();
      test_full();
      test_rst_midread();
      test_wrap();
`ifdef RAM_FIFO_FLUSH_EN
      test_flush();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
